// File: rtl/rv_dbg_pkg.sv
// Shared types and default sizing for the PC run-control / trace monitor.
package rv_dbg_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StHalted,
    StTmo
  } state_e;

  localparam int unsigned DEFAULT_DEPTH       = 16;
  localparam int unsigned DEFAULT_HALT_CYCLES = 4;
  localparam int unsigned DEFAULT_TIMEOUT     = 1024;

  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int unsigned DEFAULT_IDX_W = idx_width(DEFAULT_DEPTH);

endpackage

// File: rtl/trace_ram.sv
// DEPTH x XLEN trace store: one write port, one registered read port (read-before-write).
module trace_ram #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [XLEN-1:0]          wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [XLEN-1:0]          rdata
);

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [XLEN-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/pc_trace_monitor.sv
// Samples the core PC, records changes into a circular trace, and flags halt (self-loop)
// or run timeout. Trace readout is oldest-first and registered.
module pc_trace_monitor
  import rv_dbg_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH       = DEFAULT_DEPTH,
  parameter int unsigned HALT_CYCLES = DEFAULT_HALT_CYCLES,
  parameter int unsigned TIMEOUT     = DEFAULT_TIMEOUT,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     pc_valid,
  input  logic [XLEN-1:0]          pc_in,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [XLEN-1:0]          rd_data,
  output logic [$clog2(DEPTH):0]   trace_count,
  output logic [CNT_W-1:0]         cycle_count,
  output logic                     running,
  output logic                     halted,
  output logic                     timed_out,
  output logic                     done
);

  localparam int unsigned IdxW   = idx_width(DEPTH);
  localparam int unsigned StuckW = $clog2(HALT_CYCLES + 1);

  localparam logic [IdxW:0]       CntFull   = (IdxW + 1)'(DEPTH);
  localparam logic [StuckW-1:0]   StuckHalt = StuckW'(HALT_CYCLES);
  localparam logic [CNT_W-1:0]    TmoLast   = CNT_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [IdxW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [IdxW:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]    cyc_q, cyc_d;
  logic [StuckW-1:0]   stuck_q, stuck_d;
  logic [XLEN-1:0]     last_pc_q, last_pc_d;
  logic                last_valid_q, last_valid_d;
  logic                halted_q, halted_d;
  logic                timed_out_q, timed_out_d;
  logic                done_q, done_d;
  logic                rd_valid_q, rd_valid_d;

  logic                we;
  logic                new_pc;
  logic                repeat_pc;
  logic [IdxW-1:0]     rd_phys;
  logic [XLEN-1:0]     ram_rdata;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    cnt_d        = cnt_q;
    cyc_d        = cyc_q;
    stuck_d      = stuck_q;
    last_pc_d    = last_pc_q;
    last_valid_d = last_valid_q;
    halted_d     = halted_q;
    timed_out_d  = timed_out_q;
    we           = 1'b0;

    new_pc    = pc_valid && (!last_valid_q || (pc_in != last_pc_q));
    repeat_pc = pc_valid && last_valid_q && (pc_in == last_pc_q);

    if (start) begin
      // Same clear from any state; a start during RUN also drops that cycle's sample.
      state_d      = StRun;
      wr_ptr_d     = '0;
      cnt_d        = '0;
      cyc_d        = '0;
      stuck_d      = '0;
      last_pc_d    = '0;
      last_valid_d = 1'b0;
      halted_d     = 1'b0;
      timed_out_d  = 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (cyc_q != '1) begin
            cyc_d = cyc_q + 1'b1;
          end
          if (new_pc) begin
            we           = 1'b1;
            wr_ptr_d     = wr_ptr_q + 1'b1;
            last_pc_d    = pc_in;
            last_valid_d = 1'b1;
            stuck_d      = '0;
            if (cnt_q != CntFull) begin
              cnt_d = cnt_q + 1'b1;
            end
          end else if (repeat_pc) begin
            stuck_d = stuck_q + 1'b1;
          end
          // Halt takes priority over a coincident timeout.
          if (repeat_pc && (stuck_d == StuckHalt)) begin
            state_d  = StHalted;
            halted_d = 1'b1;
          end else if ((TIMEOUT != 0) && (cyc_q == TmoLast)) begin
            state_d     = StTmo;
            timed_out_d = 1'b1;
          end
        end
        StIdle, StHalted, StTmo: ;
        default: state_d = StIdle;
      endcase
    end

    done_d = halted_d | timed_out_d;

    rd_phys    = wr_ptr_q - cnt_q[IdxW-1:0] + rd_addr;
    rd_valid_d = ({1'b0, rd_addr} < cnt_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      cyc_q        <= '0;
      stuck_q      <= '0;
      last_pc_q    <= '0;
      last_valid_q <= 1'b0;
      halted_q     <= 1'b0;
      timed_out_q  <= 1'b0;
      done_q       <= 1'b0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      cyc_q        <= cyc_d;
      stuck_q      <= stuck_d;
      last_pc_q    <= last_pc_d;
      last_valid_q <= last_valid_d;
      halted_q     <= halted_d;
      timed_out_q  <= timed_out_d;
      done_q       <= done_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  trace_ram #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_trace_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr_q),
    .wdata (pc_in),
    .raddr (rd_phys),
    .rdata (ram_rdata)
  );

  // Out-of-range reads were flagged when the address was sampled.
  assign rd_data     = rd_valid_q ? ram_rdata : '0;
  assign trace_count = cnt_q;
  assign cycle_count = cyc_q;
  assign running     = (state_q == StRun);
  assign halted      = halted_q;
  assign timed_out   = timed_out_q;
  assign done        = done_q;

endmodule
